// File: rtl/video_serial_pkg.sv
// Shared opcodes and decoder state encoding for the serial display link responder.
package video_serial_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_INVOFF  = 8'h20;
    localparam logic [7:0] CMD_INVON   = 8'h21;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2a;
    localparam logic [7:0] CMD_RASET   = 8'h2b;
    localparam logic [7:0] CMD_RAMWR   = 8'h2c;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_COLMOD  = 8'h3a;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COL_ADDR,
        ST_ROW_ADDR,
        ST_MEM_WRITE,
        ST_MEM_WRITE_LO,
        ST_MADCTL,
        ST_COLMOD,
        ST_IGNORE
    } t_rx_state;

endpackage

// File: rtl/video_serial_rx_byte.sv
// Link front end: synchronises the five link wires, detects serial clock rising
// edges and assembles MSB-first words with their command/data flag.
module serial_byte_rx #(
    parameter int   SERIAL_BITS   = 8,
    parameter logic SELECT_ACTIVE = 1'b1
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_vid_rst,
    input  logic                   in_vid_select,
    input  logic                   in_vid_cmd,
    input  logic                   in_vid_serial_clk,
    input  logic                   in_vid_serial,
    output logic                   out_vid_rst,
    output logic                   out_byte_valid,
    output logic                   out_cmd,
    output logic [SERIAL_BITS-1:0] out_data,
    output logic                   out_partial_err
);

    localparam int CNT_BITS = $clog2(SERIAL_BITS + 1);

    logic [1:0]             r_rst_sync;
    logic [1:0]             r_sel_sync;
    logic [1:0]             r_cmd_sync;
    logic [1:0]             r_sclk_sync;
    logic [1:0]             r_sdat_sync;
    logic                   r_sclk_prev;
    logic [CNT_BITS-1:0]    r_cnt;
    logic [SERIAL_BITS-2:0] r_shift;
    logic                   r_valid;
    logic                   r_cmd;
    logic [SERIAL_BITS-1:0] r_data;
    logic                   r_err;

    logic w_rise;
    logic w_selected;
    logic w_clear;

    // Synchronisers only follow in_rst; the synced display reset must keep
    // propagating while it clears everything else. Serial clock idles high.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_rst_sync  <= 2'b00;
            r_sel_sync  <= 2'b00;
            r_cmd_sync  <= 2'b00;
            r_sclk_sync <= 2'b11;
            r_sdat_sync <= 2'b00;
            r_sclk_prev <= 1'b1;
        end else begin
            r_rst_sync  <= {r_rst_sync[0],  in_vid_rst};
            r_sel_sync  <= {r_sel_sync[0],  in_vid_select};
            r_cmd_sync  <= {r_cmd_sync[0],  in_vid_cmd};
            r_sclk_sync <= {r_sclk_sync[0], in_vid_serial_clk};
            r_sdat_sync <= {r_sdat_sync[0], in_vid_serial};
            r_sclk_prev <= r_sclk_sync[1];
        end
    end

    assign w_rise     = r_sclk_sync[1] & ~r_sclk_prev;
    assign w_selected = (r_sel_sync[1] == SELECT_ACTIVE);
    assign w_clear    = in_rst | r_rst_sync[1];

    always_ff @(posedge in_clk) begin
        if (w_clear) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_cmd   <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (!w_selected) begin
                if (r_cnt != '0)
                    r_err <= 1'b1;
                r_cnt <= '0;
            end else if (w_rise) begin
                r_shift <= {r_shift[SERIAL_BITS-3:0], r_sdat_sync[1]};
                if (r_cnt == CNT_BITS'(SERIAL_BITS - 1)) begin
                    r_cnt   <= '0;
                    r_valid <= 1'b1;
                    r_cmd   <= r_cmd_sync[1];
                    r_data  <= {r_shift, r_sdat_sync[1]};
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign out_vid_rst     = r_rst_sync[1];
    assign out_byte_valid  = r_valid;
    assign out_cmd         = r_cmd;
    assign out_data        = r_data;
    assign out_partial_err = r_err;

endmodule

// File: rtl/video_serial_rx.sv
// Serial display link responder: decodes the command subset, tracks the address
// window and emits framebuffer pixel writes with screen coordinates.
module video_serial_rx
    import video_serial_pkg::*;
#(
    parameter int   SERIAL_BITS   = 8,
    parameter int   PIXEL_BITS    = 16,
    parameter int   SCREEN_HOFFS  = 0,
    parameter int   SCREEN_VOFFS  = 0,
    parameter int   SCREEN_WIDTH  = 128,
    parameter int   SCREEN_HEIGHT = 64,
    parameter int   HCTR_BITS     = $clog2(SCREEN_WIDTH),
    parameter int   VCTR_BITS     = $clog2(SCREEN_HEIGHT),
    parameter logic SELECT_ACTIVE = 1'b1
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_vid_rst,
    input  logic                  in_vid_select,
    input  logic                  in_vid_cmd,
    input  logic                  in_vid_serial_clk,
    input  logic                  in_vid_serial,
    output logic                  out_pix_we,
    output logic [HCTR_BITS-1:0]  out_hpix,
    output logic [VCTR_BITS-1:0]  out_vpix,
    output logic [PIXEL_BITS-1:0] out_pixel,
    output logic                  out_frame_done,
    output logic                  out_awake,
    output logic                  out_disp_on,
    output logic                  out_inverted,
    output logic [7:0]            out_madctl,
    output logic [7:0]            out_colmod,
    output logic                  out_proto_err
);

    localparam logic [15:0] DEF_X_END = 16'(SCREEN_WIDTH - 1 + SCREEN_HOFFS);
    localparam logic [15:0] DEF_Y_END = 16'(SCREEN_HEIGHT - 1 + SCREEN_VOFFS);

    logic                   w_vid_rst;
    logic                   w_byte_valid;
    logic                   w_cmd;
    logic [SERIAL_BITS-1:0] w_byte;
    logic                   w_partial_err;

    serial_byte_rx #(
        .SERIAL_BITS   (SERIAL_BITS),
        .SELECT_ACTIVE (SELECT_ACTIVE)
    ) u_byte_rx (
        .in_clk            (in_clk),
        .in_rst            (in_rst),
        .in_vid_rst        (in_vid_rst),
        .in_vid_select     (in_vid_select),
        .in_vid_cmd        (in_vid_cmd),
        .in_vid_serial_clk (in_vid_serial_clk),
        .in_vid_serial     (in_vid_serial),
        .out_vid_rst       (w_vid_rst),
        .out_byte_valid    (w_byte_valid),
        .out_cmd           (w_cmd),
        .out_data          (w_byte),
        .out_partial_err   (w_partial_err)
    );

    t_rx_state              r_state;
    t_rx_state              w_state_next;
    logic [1:0]             r_param_idx;
    logic [SERIAL_BITS-1:0] r_param_hi;
    logic [15:0]            r_param_start;
    logic [15:0]            r_x_start, r_x_end, r_y_start, r_y_end;
    logic [15:0]            r_x, r_y;
    logic [SERIAL_BITS-1:0] r_pix_hi;
    logic                   r_pix_we;
    logic [HCTR_BITS-1:0]   r_hpix;
    logic [VCTR_BITS-1:0]   r_vpix;
    logic [PIXEL_BITS-1:0]  r_pixel;
    logic                   r_frame_done;
    logic                   r_awake, r_disp_on, r_inverted;
    logic [7:0]             r_madctl, r_colmod;
    logic                   r_proto_err;

    logic        w_rst, w_is_cmd, w_is_data, w_soft_rst;
    logic [15:0] w_param_word, w_end_word, w_x_rel, w_y_rel;
    logic        w_visible, w_x_wrap, w_y_wrap;

    assign w_rst      = in_rst | w_vid_rst;
    assign w_is_cmd   = w_byte_valid & ~w_cmd;
    assign w_is_data  = w_byte_valid & w_cmd;
    assign w_soft_rst = w_is_cmd && (w_byte == SERIAL_BITS'(CMD_SWRESET));

    assign w_param_word = 16'({r_param_hi, w_byte});
    assign w_end_word   = (w_param_word < r_param_start) ? r_param_start : w_param_word;

    assign w_x_rel   = r_x - 16'(SCREEN_HOFFS);
    assign w_y_rel   = r_y - 16'(SCREEN_VOFFS);
    assign w_visible = (r_x >= 16'(SCREEN_HOFFS)) && (w_x_rel < 16'(SCREEN_WIDTH)) &&
                       (r_y >= 16'(SCREEN_VOFFS)) && (w_y_rel < 16'(SCREEN_HEIGHT));
    assign w_x_wrap  = (r_x == r_x_end);
    assign w_y_wrap  = (r_y == r_y_end);

    always_ff @(posedge in_clk) begin
        if (w_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Any command byte aborts whatever is in progress.
    always_comb begin
        w_state_next = r_state;
        if (w_is_cmd) begin
            case (w_byte)
                SERIAL_BITS'(CMD_CASET):   w_state_next = ST_COL_ADDR;
                SERIAL_BITS'(CMD_RASET):   w_state_next = ST_ROW_ADDR;
                SERIAL_BITS'(CMD_RAMWR):   w_state_next = ST_MEM_WRITE;
                SERIAL_BITS'(CMD_MADCTL):  w_state_next = ST_MADCTL;
                SERIAL_BITS'(CMD_COLMOD):  w_state_next = ST_COLMOD;
                SERIAL_BITS'(CMD_SWRESET),
                SERIAL_BITS'(CMD_SLPOUT),
                SERIAL_BITS'(CMD_INVOFF),
                SERIAL_BITS'(CMD_INVON),
                SERIAL_BITS'(CMD_DISPOFF),
                SERIAL_BITS'(CMD_DISPON):  w_state_next = ST_IDLE;
                default:                   w_state_next = ST_IGNORE;
            endcase
        end else if (w_is_data) begin
            case (r_state)
                ST_COL_ADDR,
                ST_ROW_ADDR:     if (r_param_idx == 2'd3) w_state_next = ST_IDLE;
                ST_MEM_WRITE:    w_state_next = ST_MEM_WRITE_LO;
                ST_MEM_WRITE_LO: w_state_next = ST_MEM_WRITE;
                ST_MADCTL,
                ST_COLMOD:       w_state_next = ST_IDLE;
                default:         w_state_next = r_state;
            endcase
        end
    end

    // Software reset clears the same state as a hard reset, except the error flag.
    always_ff @(posedge in_clk) begin
        if (w_rst || w_soft_rst) begin
            r_param_idx   <= '0;
            r_param_hi    <= '0;
            r_param_start <= '0;
            r_x_start     <= '0;
            r_x_end       <= DEF_X_END;
            r_y_start     <= '0;
            r_y_end       <= DEF_Y_END;
            r_x           <= '0;
            r_y           <= '0;
            r_pix_hi      <= '0;
            r_pix_we      <= 1'b0;
            r_hpix        <= '0;
            r_vpix        <= '0;
            r_pixel       <= '0;
            r_frame_done  <= 1'b0;
            r_awake       <= 1'b0;
            r_disp_on     <= 1'b0;
            r_inverted    <= 1'b0;
            r_madctl      <= '0;
            r_colmod      <= '0;
        end else begin
            r_pix_we     <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_is_cmd) begin
                r_param_idx <= '0;
                case (w_byte)
                    SERIAL_BITS'(CMD_SLPOUT):  r_awake    <= 1'b1;
                    SERIAL_BITS'(CMD_DISPON):  r_disp_on  <= 1'b1;
                    SERIAL_BITS'(CMD_DISPOFF): r_disp_on  <= 1'b0;
                    SERIAL_BITS'(CMD_INVON):   r_inverted <= 1'b1;
                    SERIAL_BITS'(CMD_INVOFF):  r_inverted <= 1'b0;
                    SERIAL_BITS'(CMD_RAMWR): begin
                        r_x <= r_x_start;
                        r_y <= r_y_start;
                    end
                    default: ;
                endcase
            end else if (w_is_data) begin
                case (r_state)
                    ST_COL_ADDR, ST_ROW_ADDR: begin
                        r_param_idx <= r_param_idx + 2'd1;
                        case (r_param_idx)
                            2'd0, 2'd2: r_param_hi    <= w_byte;
                            2'd1:       r_param_start <= w_param_word;
                            default: begin
                                if (r_state == ST_COL_ADDR) begin
                                    r_x_start <= r_param_start;
                                    r_x_end   <= w_end_word;
                                end else begin
                                    r_y_start <= r_param_start;
                                    r_y_end   <= w_end_word;
                                end
                            end
                        endcase
                    end
                    ST_MEM_WRITE: r_pix_hi <= w_byte;
                    ST_MEM_WRITE_LO: begin
                        r_pixel  <= PIXEL_BITS'({r_pix_hi, w_byte});
                        r_hpix   <= w_x_rel[HCTR_BITS-1:0];
                        r_vpix   <= w_y_rel[VCTR_BITS-1:0];
                        r_pix_we <= w_visible;
                        // Raster order inside the window, wrapping to the next frame.
                        if (w_x_wrap) begin
                            r_x <= r_x_start;
                            if (w_y_wrap) begin
                                r_y          <= r_y_start;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_y <= r_y + 16'd1;
                            end
                        end else begin
                            r_x <= r_x + 16'd1;
                        end
                    end
                    ST_MADCTL: r_madctl <= 8'(w_byte);
                    ST_COLMOD: r_colmod <= 8'(w_byte);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (w_rst)
            r_proto_err <= 1'b0;
        else if (w_partial_err || (w_is_data && r_state == ST_IDLE))
            r_proto_err <= 1'b1;
    end

    assign out_pix_we     = r_pix_we;
    assign out_hpix       = r_hpix;
    assign out_vpix       = r_vpix;
    assign out_pixel      = r_pixel;
    assign out_frame_done = r_frame_done;
    assign out_awake      = r_awake;
    assign out_disp_on    = r_disp_on;
    assign out_inverted   = r_inverted;
    assign out_madctl     = r_madctl;
    assign out_colmod     = r_colmod;
    assign out_proto_err  = r_proto_err;

endmodule

// File: tb/tb_video_serial_rx.sv
// Directed bench for video_serial_rx: a default instance plus a column-offset
// instance share one link; pixel strobes are captured into queues and compared.
module tb_video_serial_rx;

    logic clk = 1'b0;
    logic rst, vid_rst, sel, cmd, sclk, sdat;

    logic        we1, fd1, awake1, dispon1, inv1, perr1;
    logic [6:0]  h1;
    logic [5:0]  v1;
    logic [15:0] p1;
    logic [7:0]  madctl1, colmod1;

    logic        we2, fd2, awake2, dispon2, inv2, perr2;
    logic [6:0]  h2;
    logic [5:0]  v2;
    logic [15:0] p2;
    logic [7:0]  madctl2, colmod2;

    always #5 clk = ~clk;

    video_serial_rx dut (
        .in_clk(clk), .in_rst(rst), .in_vid_rst(vid_rst), .in_vid_select(sel),
        .in_vid_cmd(cmd), .in_vid_serial_clk(sclk), .in_vid_serial(sdat),
        .out_pix_we(we1), .out_hpix(h1), .out_vpix(v1), .out_pixel(p1),
        .out_frame_done(fd1), .out_awake(awake1), .out_disp_on(dispon1),
        .out_inverted(inv1), .out_madctl(madctl1), .out_colmod(colmod1),
        .out_proto_err(perr1)
    );

    video_serial_rx #(.SCREEN_HOFFS(40)) dut_off (
        .in_clk(clk), .in_rst(rst), .in_vid_rst(vid_rst), .in_vid_select(sel),
        .in_vid_cmd(cmd), .in_vid_serial_clk(sclk), .in_vid_serial(sdat),
        .out_pix_we(we2), .out_hpix(h2), .out_vpix(v2), .out_pixel(p2),
        .out_frame_done(fd2), .out_awake(awake2), .out_disp_on(dispon2),
        .out_inverted(inv2), .out_madctl(madctl2), .out_colmod(colmod2),
        .out_proto_err(perr2)
    );

    typedef struct {
        logic        we;
        logic [6:0]  h;
        logic [5:0]  v;
        logic [15:0] p;
        logic        fd;
    } pix_t;

    typedef struct {
        logic [15:0] pix;
        logic [6:0]  h;
        logic [5:0]  v;
        logic        fd;
    } vec_t;

    pix_t q1[$];
    pix_t q2[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge clk) begin
        if (we1 || fd1) q1.push_back('{we1, h1, v1, p1, fd1});
        if (we2 || fd2) q2.push_back('{we2, h2, v2, p2, fd2});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_pix(input int which, input string name, input logic [6:0] h,
                           input logic [5:0] v, input logic [15:0] p, input logic fd);
        pix_t g;
        n_checks++;
        if ((which == 1 ? q1.size() : q2.size()) == 0) begin
            n_fail++;
            $display("FAIL %s: no strobe, required h=%0d v=%0d p=%h fd=%0d", name, h, v, p, fd);
        end else begin
            g = (which == 1) ? q1.pop_front() : q2.pop_front();
            if (g.we !== 1'b1 || g.h !== h || g.v !== v || g.p !== p || g.fd !== fd) begin
                n_fail++;
                $display("FAIL %s: got we=%0d h=%0d v=%0d p=%h fd=%0d required we=1 h=%0d v=%0d p=%h fd=%0d",
                         name, g.we, g.h, g.v, g.p, g.fd, h, v, p, fd);
            end
        end
    endtask

    task automatic send_byte(input logic c, input logic [7:0] b);
        sel = 1'b1;
        cmd = c;
        for (int i = 7; i >= 0; i--) begin
            sclk = 1'b0;
            sdat = b[i];
            tick(3);
            sclk = 1'b1;
            tick(2);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_byte(1'b0, b);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_byte(1'b1, b);
    endtask

    task automatic send_window(input logic [7:0] op, input logic [15:0] s, input logic [15:0] e);
        send_cmd(op);
        send_data(s[15:8]);
        send_data(s[7:0]);
        send_data(e[15:8]);
        send_data(e[7:0]);
    endtask

    task automatic send_pix(input logic [15:0] px);
        send_data(px[15:8]);
        send_data(px[7:0]);
        tick(6);
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{16'hF800, 7'd0, 6'd0, 1'b0};
        tbl[1] = '{16'h07E0, 7'd1, 6'd0, 1'b0};
        tbl[2] = '{16'h001F, 7'd0, 6'd1, 1'b0};
        tbl[3] = '{16'hFFFF, 7'd1, 6'd1, 1'b1};

        rst = 1'b1; vid_rst = 1'b0; sel = 1'b0; cmd = 1'b0; sclk = 1'b1; sdat = 1'b0;
        tick(4);
        chk("rst_pix_we", {31'd0, we1}, 32'd0);
        chk("rst_awake",  {31'd0, awake1}, 32'd0);
        chk("rst_madctl", {24'd0, madctl1}, 32'd0);
        chk("rst_perr",   {31'd0, perr1}, 32'd0);
        rst = 1'b0;
        tick(4);

        // Immediate commands
        send_cmd(8'h11);
        send_cmd(8'h29);
        send_cmd(8'h21);
        tick(6);
        chk("awake",    {31'd0, awake1}, 32'd1);
        chk("disp_on",  {31'd0, dispon1}, 32'd1);
        chk("inverted", {31'd0, inv1}, 32'd1);
        chk("no_strobe_cmds", q1.size(), 32'd0);

        // 2x2 window, table-driven pixels
        send_window(8'h2a, 16'd0, 16'd1);
        send_window(8'h2b, 16'd0, 16'd1);
        send_cmd(8'h2c);
        for (int i = 0; i < 4; i++) begin
            send_pix(tbl[i].pix);
            chk_pix(1, $sformatf("tbl_pix%0d", i), tbl[i].h, tbl[i].v, tbl[i].pix, tbl[i].fd);
        end
        chk("tbl_extra", q1.size(), 32'd0);

        // Column offset: x 39..40 on a single row
        q2.delete();
        send_window(8'h2a, 16'h0027, 16'h0028);
        send_window(8'h2b, 16'd0, 16'd0);
        send_cmd(8'h2c);
        send_pix(16'h1234);
        chk("off_first_suppressed", q2.size(), 32'd0);
        send_pix(16'h5678);
        chk_pix(2, "off_second", 7'd0, 6'd0, 16'h5678, 1'b1);
        chk_pix(1, "nooff_x39", 7'd39, 6'd0, 16'h1234, 1'b0);
        chk_pix(1, "nooff_x40", 7'd40, 6'd0, 16'h5678, 1'b1);
        chk("perr_clean", {31'd0, perr1}, 32'd0);

        // Partial byte then MADCTL/COLMOD
        sel = 1'b1; cmd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b0; sdat = 1'b1; tick(3);
            sclk = 1'b1; tick(2);
        end
        sel = 1'b0;
        tick(6);
        chk("partial_perr", {31'd0, perr1}, 32'd1);
        send_cmd(8'h36);
        send_data(8'h88);
        send_cmd(8'h3a);
        send_data(8'h55);
        tick(6);
        chk("madctl", {24'd0, madctl1}, 32'h88);
        chk("colmod", {24'd0, colmod1}, 32'h55);
        chk("partial_no_strobe", q1.size(), 32'd0);

        // Column window change in the middle of a pixel
        send_window(8'h2a, 16'd0, 16'd1);
        send_window(8'h2b, 16'd0, 16'd1);
        send_cmd(8'h2c);
        send_data(8'hAB);
        send_window(8'h2a, 16'd2, 16'd3);
        tick(6);
        chk("abort_no_strobe", q1.size(), 32'd0);
        send_cmd(8'h2c);
        send_pix(16'h1111);
        chk_pix(1, "abort_new_window", 7'd2, 6'd0, 16'h1111, 1'b0);

        // End below start clamps to a single column
        send_window(8'h2a, 16'd5, 16'd3);
        send_cmd(8'h2c);
        send_pix(16'h2222);
        chk_pix(1, "clamp_p0", 7'd5, 6'd0, 16'h2222, 1'b0);
        send_pix(16'h3333);
        chk_pix(1, "clamp_p1", 7'd5, 6'd1, 16'h3333, 1'b1);

        // Software reset keeps the error flag
        send_cmd(8'h01);
        tick(6);
        chk("swrst_awake",  {31'd0, awake1}, 32'd0);
        chk("swrst_madctl", {24'd0, madctl1}, 32'd0);
        chk("swrst_perr",   {31'd0, perr1}, 32'd1);

        // Display reset mid-frame
        send_cmd(8'h11);
        send_cmd(8'h29);
        send_cmd(8'h36);
        send_data(8'h77);
        send_cmd(8'h2c);
        send_pix(16'hAAAA);
        chk_pix(1, "pre_vrst", 7'd0, 6'd0, 16'hAAAA, 1'b0);
        send_data(8'hBB);
        vid_rst = 1'b1;
        tick(3);
        chk("vrst_awake",   {31'd0, awake1}, 32'd0);
        chk("vrst_dispon",  {31'd0, dispon1}, 32'd0);
        chk("vrst_madctl",  {24'd0, madctl1}, 32'd0);
        chk("vrst_perr",    {31'd0, perr1}, 32'd0);
        chk("vrst_pix_we",  {31'd0, we1}, 32'd0);
        vid_rst = 1'b0;
        tick(4);
        chk("vrst_no_strobe", q1.size(), 32'd0);
        send_cmd(8'h2c);
        send_pix(16'hBEEF);
        chk_pix(1, "post_vrst_p0", 7'd0, 6'd0, 16'hBEEF, 1'b0);
        send_pix(16'h1357);
        chk_pix(1, "post_vrst_p1", 7'd1, 6'd0, 16'h1357, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_serial_rx.md
Name: video_serial_rx

Overview:
- Responder end of the 4-wire serial display link (reset, chip select, command/data, serial clock, serial data), as driven by the team's serial display controller.
- Oversamples the link on the system clock, assembles MSB-first bytes, and decodes the display command subset: 0x01, 0x11, 0x20, 0x21, 0x28, 0x29, 0x2a, 0x2b, 0x2c, 0x36, 0x3a.
- Emits pixel writes with screen coordinates into a framebuffer port.
- Used as a display model in benches and as an FPGA display-emulation front end.

Parameters:
SERIAL_BITS, 8, bits per link word
PIXEL_BITS, 16, pixel width (two link bytes, high byte first)
SCREEN_HOFFS, 0, column offset subtracted from link column addresses
SCREEN_VOFFS, 0, row offset subtracted from link row addresses
SCREEN_WIDTH, 128, visible columns
SCREEN_HEIGHT, 64, visible rows
HCTR_BITS, $clog2(SCREEN_WIDTH), output column width
VCTR_BITS, $clog2(SCREEN_HEIGHT), output row width
SELECT_ACTIVE, 1'b1, chip-select level meaning "selected"

Ports:
in_clk  in  1  system clock, >= 4x serial clock
in_rst  in  1  synchronous active-high reset
in_vid_rst  in  1  display reset line, active high
in_vid_select  in  1  chip select
in_vid_cmd  in  1  0: command byte, 1: parameter/data byte
in_vid_serial_clk  in  1  serial clock, idle high
in_vid_serial  in  1  serial data, sampled on serial clock rising edge
out_pix_we  out  1  one-cycle pixel write strobe
out_hpix  out  HCTR_BITS  pixel column
out_vpix  out  VCTR_BITS  pixel row
out_pixel  out  PIXEL_BITS  pixel value
out_frame_done  out  1  one-cycle pulse after the last pixel of the window
out_awake  out  1  sleep-out (0x11) received
out_disp_on  out  1  display on (0x29), off (0x28)
out_inverted  out  1  inversion on (0x21), off (0x20)
out_madctl  out  8  last 0x36 parameter
out_colmod  out  8  last 0x3a parameter
out_proto_err  out  1  sticky protocol error flag

Behaviour:
- Input synchronisation: all five link inputs pass through 2-flop synchronisers. A rising edge is flagged when the synced serial clock is 1 and its previous sample was 0.
- Bit assembly:
  - While selected, each rising edge shifts the synced data in MSB first.
  - The cmd bit is latched on the 8th edge.
  - byte_valid is high for 1 cycle in the cycle after the 8th edge.
  - When deselected, the bit counter clears; a partial byte is discarded and sets out_proto_err.
- Reset:
  - in_rst, or synced in_vid_rst high, clears all state and outputs to 0.
  - Window resets to x 0..SCREEN_WIDTH-1+HOFFS and y 0..SCREEN_HEIGHT-1+VOFFS, both with offsets applied.
  - Command 0x01 has the same effect, except out_proto_err is kept.
- Decoder FSM states: Idle, ColAddr, RowAddr, MemWrite, MemWriteLo, Madctl, Colmod, Ignore.
  - A byte with cmd=0 always aborts the current state and decodes as a new command. Parameter index is reset to 0.
  - 0x2a → ColAddr, 0x2b → RowAddr: 4 params (start hi, start lo, end hi, end lo). Commit on the 4th param, then go to Idle.
  - If end < start, end := start.
  - 0x2c: pointer := (x_start, y_start), → MemWrite.
  - 0x36 → Madctl, 0x3a → Colmod: 1 param, then Idle.
  - 0x01, 0x11, 0x20, 0x21, 0x28, 0x29: act immediately, stay Idle.
  - Any other opcode → Ignore; data bytes are dropped until the next command.
  - Data byte in Idle: dropped, sets out_proto_err.
- Pixel path:
  - MemWrite latches the high byte, → MemWriteLo.
  - MemWriteLo forms the pixel and pulses out_pix_we 1 cycle after that byte_valid. Total latency is 2 in_clk cycles after the final synced edge.
  - out_hpix = x - HOFFS and out_vpix = y - VOFFS, truncated.
  - out_pix_we is suppressed (pointer still advances) if x < HOFFS, x - HOFFS >= SCREEN_WIDTH, or the equivalent holds for y.
- Pointer advance:
  - x++; at x_end, x := x_start and y++.
  - At x_end and y_end together: pointer := start, and out_frame_done pulses in the same cycle as that write strobe.
  - Data then continues into the next frame.
- Coordinate arithmetic: all window and pointer arithmetic is 16-bit unsigned.

Decomposition:
- Package video_serial_pkg holds:
  - command opcode constants (CMD_SWRESET 0x01, CMD_SLPOUT 0x11, CMD_INVOFF 0x20, CMD_INVON 0x21, CMD_DISPOFF 0x28, CMD_DISPON 0x29, CMD_CASET 0x2a, CMD_RASET 0x2b, CMD_RAMWR 0x2c, CMD_MADCTL 0x36, CMD_COLMOD 0x3a);
  - t_rx_state enum.
- One sub-module, serial_byte_rx: synchronisers, edge detect, shift register, byte_valid/cmd/data outputs, partial-byte error.

Test Plan:
- Send 0x11, 0x29, 0x21 at SERIAL_CLK = MAIN_CLK/5 → out_awake=1, out_disp_on=1, out_inverted=1; no pixel strobes.
- Send CASET 00 00 00 01, RASET 00 00 00 01, RAMWR, then 4 pixels 0xF800, 0x07E0, 0x001F, 0xFFFF → strobes at (0,0) F800, (1,0) 07E0, (0,1) 001F, (1,1) FFFF; out_frame_done coincides with the 4th strobe.
- SCREEN_HOFFS=40, CASET 00 27 00 28 (x 39..40) → first pixel suppressed, second written at out_hpix=0.
- Drop select after 5 bits of a data byte, then send cmd 0x36 + 0x88 → out_proto_err=1, out_madctl=0x88, no spurious byte.
- Mid-RAMWR (after the high byte), send cmd 0x2a → no strobe; the FSM accepts the new column window.
- Assert in_vid_rst mid-frame → all outputs 0 within 3 cycles, window back to default, the next RAMWR starts at (0,0).
